clocked_token_injector: RTL
===========================

Name: clocked_token_injector

Overview:
- Synchronous-to-self-timed bridge at the head of a C-element token pipeline.
- Accepts tokens from clocked logic on a valid/ready interface and drives the first C-element stage with a 4-phase return-to-zero request (SENDOUT) and data (DOUT).
- Samples that stage's returned acknowledge (ACKIN) through a synchronizer.
- Counts completed handshakes and flags a stalled pipeline via a watchdog.

Parameters:
- DATA_W, 8, width of token payload.
- SYNC_STAGES, 2, flops in ACKIN synchronizer (legal 2..4).
- TIMEOUT, 1023, cycles a handshake phase may wait before TIMEOUT_ERR sets; 0 disables the watchdog.
- CNT_W, 16, width of completed-token counter.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous active-high reset; also inverted externally to drive the downstream stage RESETN.
- ENABLE  in  1  permits acceptance of new tokens.
- IN_VALID  in  1  upstream token valid.
- IN_READY  out  1  injector can accept a token this cycle.
- IN_DATA  in  DATA_W  upstream payload.
- SENDOUT  out  1  4-phase request to the C-element stage's SENDIN; registered, glitch-free.
- DOUT  out  DATA_W  payload to the stage; registered.
- ACKIN  in  1  asynchronous acknowledge from the stage's ACKOUT.
- TOKEN_CNT  out  CNT_W  completed handshakes, wrapping.
- TIMEOUT_ERR  out  1  sticky watchdog flag.
- BUSY  out  1  handshake in progress (state != IDLE).

Behaviour:
- Reset values: SENDOUT=0, DOUT=0, TOKEN_CNT=0, TIMEOUT_ERR=0, BUSY=0, IN_READY=0, all synchronizer flops=0, state=IDLE, watchdog=0.
- ack_s: ACKIN after SYNC_STAGES flops. Only ack_s is used in logic; raw ACKIN never reaches logic.
- IN_READY is combinational: (state==IDLE) && ENABLE && !ack_s && !RESET.
- FSM states IDLE, REQ, RELEASE:
  - IDLE: if IN_VALID && IN_READY at edge k → DOUT<=IN_DATA, SENDOUT<=1, state<=REQ. SENDOUT is visible after edge k.
  - REQ: SENDOUT held 1, DOUT held stable. When ack_s==1 → SENDOUT<=0, state<=RELEASE.
  - RELEASE: SENDOUT 0, DOUT still held. When ack_s==0 → TOKEN_CNT<=TOKEN_CNT+1 (mod 2^CNT_W), state<=IDLE.
- DOUT changes only on acceptance. It is stable from the SENDOUT rising edge through the end of RELEASE (bundled-data constraint).
- Token throughput: one token per 2*SYNC_STAGES + 3 cycles minimum when the stage acks instantly (handshake round trip with no stage delay).
- Watchdog:
  - Counter clears on every state change. It increments each cycle in REQ or RELEASE while the state is unchanged.
  - When it reaches TIMEOUT (TIMEOUT!=0), TIMEOUT_ERR<=1 and the counter saturates.
  - The FSM does not abort: an async handshake cannot be withdrawn, so SENDOUT holds its level.
  - TIMEOUT_ERR clears only on RESET.
- ENABLE deasserted mid-handshake: the current handshake completes normally; no new acceptance until ENABLE=1.
- Stale ack in IDLE (ack_s==1, e.g. just after reset): IN_READY=0 until ack_s==0. No spurious handshake.
- RESET mid-handshake: all state returns to reset values next edge and SENDOUT drops. The downstream stage is reset by the same signal, so no half-finished token survives.
- TOKEN_CNT wrap: all-ones + 1 → 0, no flag.
- Simultaneous IN_VALID and RESET: reset wins; the token is not accepted.

Decomposition:
- Shared package cues_hs_pkg: state enum (IDLE, REQ, RELEASE) and a constant for the default synchronizer depth, shared with the future clocked_token_collector at the pipeline tail.
- One sub-module: hs_sync (SYNC_STAGES-deep reset-to-0 single-bit synchronizer). It is reused by the collector on its SENDIN input.
- FSM, data register, counter and watchdog stay in the top module.

Test Plan:
- Single token: reset, ENABLE=1, IN_DATA=0xA5 valid 1 cycle; stage model acks 3 cycles after SENDOUT rise and releases 3 cycles after fall → DOUT=0xA5 stable throughout, SENDOUT one 4-phase pulse, TOKEN_CNT=1, IN_READY back to 1 in IDLE.
- Back-to-back stream: 10 tokens 0x00..0x09 with IN_VALID held high, zero-delay ack model → 10 handshakes in order, TOKEN_CNT=10, each token takes exactly 2*SYNC_STAGES+3 cycles.
- Stalled pipeline: TIMEOUT=16, ACKIN held 0 after the request → TIMEOUT_ERR=1 after 16 cycles in REQ, SENDOUT stays 1. A later ack completes the handshake, TOKEN_CNT=1, TIMEOUT_ERR stays 1.
- Stale ack: ACKIN=1 at reset release → IN_READY=0 while ack_s=1. Drop ACKIN → IN_READY=1 after SYNC_STAGES cycles.
- Mid-handshake disturbance: ENABLE=0 during REQ → handshake completes, no further acceptance. Separately, RESET asserted in RELEASE → next edge all outputs at reset values, TOKEN_CNT=0.
- Counter wrap: CNT_W=4, 17 tokens → TOKEN_CNT=1.

Source files
------------

// File: rtl/cues_hs_pkg.sv
// cues_hs_pkg: handshake state encoding and defaults shared by the
// clocked injector/collector pair at the ends of the C-element pipeline.
package cues_hs_pkg;
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } hs_state_e;
    localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/hs_sync.sv
// hs_sync: multi-flop single-bit synchronizer that clears to 0 on reset,
// used for signals coming back from the self-timed domain.
module hs_sync #(
    parameter int STAGES = cues_hs_pkg::SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) ff <= rst ? '0 : {ff[STAGES-2:0], d};

    assign q = ff[STAGES-1];
endmodule

// File: rtl/clocked_token_injector.sv
// clocked_token_injector: turns valid/ready tokens into 4-phase RZ
// request/data for the first C-element stage, with token count and watchdog.
module clocked_token_injector
    import cues_hs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT     = 1023,
    parameter int CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              SENDOUT,
    output logic [DATA_W-1:0] DOUT,
    input  logic              ACKIN,
    output logic [CNT_W-1:0]  TOKEN_CNT,
    output logic              TIMEOUT_ERR,
    output logic              BUSY
);
    localparam int WD_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    hs_state_e         state, state_nxt;
    logic              ack_s, send_nxt, err_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;

    hs_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(CLK),
        .rst(RESET),
        .d  (ACKIN),
        .q  (ack_s)
    );

    // A stale ack_s in IDLE would otherwise start a handshake the stage cannot see.
    assign IN_READY = (state == IDLE) && ENABLE && !ack_s && !RESET;
    assign BUSY     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        send_nxt  = SENDOUT;
        dout_nxt  = DOUT;
        cnt_nxt   = TOKEN_CNT;
        unique case (state)
            IDLE: if (IN_VALID && IN_READY) begin
                dout_nxt  = IN_DATA;
                send_nxt  = 1'b1;
                state_nxt = REQ;
            end
            REQ: if (ack_s) begin
                send_nxt  = 1'b0;
                state_nxt = RELEASE;
            end
            RELEASE: if (!ack_s) begin
                cnt_nxt   = TOKEN_CNT + CNT_W'(1);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // The watchdog only reports; a 4-phase request cannot be withdrawn.
        wd_nxt  = (state_nxt != state || !BUSY) ? '0 : (wd == WD_MAX ? wd : wd + WD_W'(1));
        err_nxt = TIMEOUT_ERR || (TIMEOUT != 0 && BUSY && state_nxt == state && wd_nxt == WD_MAX);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            SENDOUT     <= 1'b0;
            DOUT        <= '0;
            TOKEN_CNT   <= '0;
            TIMEOUT_ERR <= 1'b0;
            wd          <= '0;
        end else begin
            state       <= state_nxt;
            SENDOUT     <= send_nxt;
            DOUT        <= dout_nxt;
            TOKEN_CNT   <= cnt_nxt;
            TIMEOUT_ERR <= err_nxt;
            wd          <= wd_nxt;
        end
    end
endmodule
